// File: rtl/freq_div_pkg.sv
// Shared definitions for the runtime-programmable clock divider.
// Contents:
//   MIN_DIV     - smallest divisor the counter will run with
//   run_state_e - run state (IDLE / RUN)
//   clamp_div() - maps a requested divisor onto the legal range
package freq_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_e;

  // Divisors of 0 or 1 cannot produce a period, so they run as MIN_DIV.
  function automatic int unsigned clamp_div(input int unsigned v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/freq_div_duty_gen.sv
// Divided-clock shaper for freq_divider_n. Holds the only negedge flop
// of the divider, so the dual-edge logic is kept in one place.
// Ports:
//   clk, rst_n         - clock and async active-low reset
//   run_d/count_d/div_d - next-cycle run flag, phase and divisor
//   run_q/count_q/div_q - current run flag, phase and divisor
//   clk_out            - divided clock (50% duty or 1/N pulse)
module freq_div_duty_gen #(
  parameter int unsigned WIDTH  = 4,
  parameter bit          DUTY50 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_d,
  input  logic [WIDTH-1:0] count_d,
  input  logic [WIDTH-1:0] div_d,
  input  logic             run_q,
  input  logic [WIDTH-1:0] count_q,
  input  logic [WIDTH-1:0] div_q,
  output logic             clk_out
);

  logic           q_p_q, q_p_d;
  logic           q_n_q, q_n_d;
  logic [WIDTH:0] half_d;
  logic           duty_clk;
  logic           pulse_clk;

  // High phases = ceil(N/2): N/2 for even N, (N+1)/2 for odd N.
  // Computed from next-cycle values so q_p lines up with count.
  always_comb begin
    half_d = ({1'b0, div_d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    q_p_d  = run_d & ({1'b0, count_d} < half_d);
    q_n_d  = q_p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_p_q <= 1'b0;
    else        q_p_q <= q_p_d;
  end

  // Half-cycle delayed copy; ANDing it trims half a period off the
  // leading edge so odd N gets exactly N/2 periods high.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q_n_q <= 1'b0;
    else        q_n_q <= q_n_d;
  end

  always_comb begin
    duty_clk  = div_q[0] ? (q_p_q & q_n_q) : q_p_q;
    pulse_clk = run_q & (count_q == '0);
    clk_out   = DUTY50 ? duty_clk : pulse_clk;
  end

endmodule

// File: rtl/freq_divider_n.sv
// Runtime-programmable integer clock divider (N = 2 .. 2^WIDTH-1).
// Ports:
//   clk, rst_n - clock and async active-low reset
//   start      - level run enable; low holds idle with count cleared
//   div_val    - requested divisor, sampled on start and at each wrap
//   count      - current phase 0..N-1 (0 when idle)
//   tick       - one cycle high on the last phase of each period
//   clk_out    - divided clock, low when idle
//   busy       - high while running
//   cfg_err    - sticky flag: a loaded divisor was 0 or 1
//
// state | meaning
// IDLE  | stopped, count held at 0, waiting for start
// RUN   | counting phases, reloading divisor at each wrap
module freq_divider_n
  import freq_div_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter bit          DUTY50 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] div_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(MIN_DIV);

  run_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             cfg_err_q, cfg_err_d;

  logic [WIDTH:0]   count_inc;
  logic             at_end;
  logic             div_bad;
  logic [WIDTH-1:0] load_val;

  // div_q >= 2 always, so div_q - 1 cannot underflow.
  assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  assign at_end    = (count_q == (div_q - ONE));
  assign div_bad   = (div_val < DIV_RST);
  assign load_val  = WIDTH'(clamp_div(32'(div_val)));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    div_d     = div_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          count_d   = '0;
          div_d     = load_val;
          cfg_err_d = cfg_err_q | div_bad;
        end
      end
      RUN: begin
        if (!start) begin
          state_d = IDLE;
          count_d = '0;
        end else if (at_end) begin
          count_d   = '0;
          div_d     = load_val;
          cfg_err_d = cfg_err_q | div_bad;
        end else begin
          count_d = count_inc[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      div_q     <= DIV_RST;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      div_q     <= div_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  freq_div_duty_gen #(
    .WIDTH  (WIDTH),
    .DUTY50 (DUTY50)
  ) u_duty_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_d   (state_d == RUN),
    .count_d (count_d),
    .div_d   (div_d),
    .run_q   (state_q == RUN),
    .count_q (count_q),
    .div_q   (div_q),
    .clk_out (clk_out)
  );

  assign busy    = (state_q == RUN);
  assign tick    = busy & at_end;
  assign count   = count_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/freq_divider_n.md
Name: freq_divider_n

Overview:
Parametrised, runtime-programmable integer clock divider, the successor to the fixed divide-by-3 counter. Divides clk by any N in 2..2^WIDTH-1, loaded from div_val. It produces a 50%-duty divided clock for even and odd N, a one-cycle terminal tick, and the live phase count. It sits in the clock-generation area, feeding enables and divided clocks to downstream logic.

Parameters:
WIDTH, 4, bit width of div_val and count; maximum divisor 2^WIDTH-1
DUTY50, 1, selects clk_out shape: 1 = 50% duty (half-cycle resolution for odd N); 0 = single-cycle pulse at count==0

Ports:
clk  in  1  input clock; the only clock
rst_n  in  1  asynchronous active-low reset
start  in  1  run enable, level-sensitive; 0 = hold idle, count cleared
div_val  in  WIDTH  requested divisor N; sampled only at load points
count  out  WIDTH  current phase, 0..N-1 while running, 0 when idle
tick  out  1  high for exactly one clk cycle when count==N-1 while running
clk_out  out  1  divided clock, low when idle
busy  out  1  high while running
cfg_err  out  1  sticky; set when a loaded div_val was 0 or 1

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, div_q=2, run=0, q_p=0, q_n=0, tick=0, clk_out=0, busy=0, cfg_err=0.
- All state updates on posedge clk, except q_n, which is a negedge flop of the same clk.
- States:
  - IDLE (run=0), RUN (run=1).
  - IDLE with start=1 -> RUN. At that edge: count<=0, div_q<=clamp(div_val).
  - RUN with start=0 -> IDLE at the next edge. count<=0, q_p<=0. clk_out is low within half a cycle.
  - RUN with start=1: count<=count+1, wrapping to 0 when count==div_q-1.
- Load points are IDLE->RUN and every wrap (count==div_q-1). div_val changes at any other time have no effect until the next load point. Periods are never truncated.
- clamp(v) = 2 if v<2, else v. A load with v<2 sets cfg_err=1. cfg_err clears only on reset.
- busy = run. tick = run & (count==div_q-1), decoded from registers with no input path.
- q_p is registered and aligned with count.
  - Even N: q_p=1 for count 0..N/2-1.
  - Odd N: q_p=1 for count 0..(N-1)/2.
- q_n samples q_p on negedge clk.
- clk_out when DUTY50=1:
  - even div_q: clk_out = q_p.
  - odd div_q: clk_out = q_p & q_n, giving high time N/2 clk periods.
- clk_out when DUTY50=0: clk_out = run & (count==0), i.e. 1/N duty.
- First RUN cycle: count=0, q_p=1, so clk_out rises one edge after start is sampled high. Latency start->first tick is N cycles.
- Width rule: the increment is WIDTH+1 bits internally. The compare uses div_q-1, which never underflows because div_q>=2. N=2^WIDTH-1 is legal.
- start toggled with div_val changed in the same cycle: the new value is loaded on re-entry.

Decomposition:
- Package freq_div_pkg holds: clamp function; MIN_DIV=2 constant; run-state typedef (IDLE/RUN).
- One natural sub-module, freq_div_duty_gen: takes count and div_q, produces q_p/q_n and clk_out, including the negedge flop. This isolates the dual-edge logic for lint and STA review.
- The counter and load control stay in the top level.

Test Plan:
- rst_n low, then start=1, div_val=3 -> count 0,1,2,0,1,2; tick on every count==2; clk_out high 1.5 clk periods out of 3; busy=1.
- div_val=4 -> clk_out high for count 0,1 and low for count 2,3 (exactly 50%); tick period 4.
- Running at N=3, div_val changed to 5 while count=1 -> N=3 period completes, then count 0..4 with tick at 4; no runt pulse on clk_out.
- start dropped at count=2 with N=5 -> next edge count=0, busy=0, tick=0, clk_out=0; re-assert start -> restarts at count 0.
- div_val=1 at start -> behaves as N=2 (count 0,1, clk_out 50%), cfg_err=1 and stays set after div_val=6 reload; only rst_n clears it.
- rst_n asserted asynchronously mid-period (between edges) -> all outputs 0 immediately. WIDTH=4, div_val=15 -> period 15, high time 7.5 cycles.
